snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
- Shared-bus controller on the opposite side of the MSI cache bus handshake.
- Arbitrates bus requests from NUM_CPUS snooping caches with round-robin priority and grants one owner.
- Captures the owner's bus message and address, broadcasts them to all caches for one cycle, and collects flush responses.
- Returns data-valid to the owner, either from a flushing cache or after a fixed memory latency.

Parameters:
- NUM_CPUS, 2, number of cache ports (min 2).
- ADDR_WIDTH, 2, line address width.
- MEM_LATENCY, 4, memory-fill cycles when no cache flushes (0 behaves as 1).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous active-high reset.
- bus_req_i  input  NUM_CPUS  per-cache bus request.
- bus_gnt_o  output  NUM_CPUS  one-hot grant, one-cycle pulse.
- cpu_msg_i  input  3*NUM_CPUS  per-cache bus message; slice i = [3*i+2:3*i]; encoding: 0 Idle, 1 Rd, 2 RdX, 3 Upgr.
- cpu_addr_i  input  ADDR_WIDTH*NUM_CPUS  per-cache line address.
- flush_i  input  NUM_CPUS  per-cache flush response.
- bus_msg_o  output  3  broadcast message.
- bus_addr_o  output  ADDR_WIDTH  broadcast address.
- bus_owner_o  output  NUM_CPUS  one-hot current owner; 0 when idle.
- data_valid_o  output  NUM_CPUS  one-hot data-valid pulse to the owner.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_i=1):
  - FSM goes to IDLE.
  - All outputs are 0.
  - last_owner = NUM_CPUS-1, so CPU0 has first priority after reset.
  - Reset mid-transaction abandons the transaction; no data_valid is issued.
- FSM states: IDLE, GRANT, BCAST, MEM_WAIT, DONE.
- IDLE:
  - If any bus_req_i bit is set, register winner w = first requester searching from last_owner+1 upward, with wrap-around.
  - Go to GRANT. Otherwise stay.
- GRANT (1 cycle):
  - bus_gnt_o[w]=1 and bus_owner_o[w]=1.
  - Sample cpu_msg_i slice w and cpu_addr_i slice w at the end of the cycle.
  - Sampled msg 0 or any value 4-7: abort; go to IDLE with last_owner=w; no broadcast.
  - Otherwise go to BCAST.
- BCAST (exactly 1 cycle):
  - bus_msg_o and bus_addr_o carry the captured values.
  - Sample flush_i with the owner's bit masked.
  - Next state:
    - msg=Upgr: DONE.
    - Any non-owner flush: DONE.
    - Otherwise: MEM_WAIT with counter loaded to max(MEM_LATENCY,1).
  - A flush during Upgr is ignored.
- MEM_WAIT:
  - Counter decrements each cycle.
  - Go to DONE on the cycle the counter reaches 1.
  - flush_i is ignored.
- DONE (1 cycle):
  - data_valid_o[w]=1.
  - last_owner=w.
  - Go to IDLE.
- Outputs outside these states:
  - bus_msg_o=0 and bus_addr_o=0 outside BCAST.
  - bus_owner_o holds w from GRANT through DONE.
- Latency, with request in IDLE at cycle 0:
  - gnt at cycle 1.
  - broadcast at cycle 2.
  - data_valid at cycle 3 (flush or Upgr), or at cycle 2+max(MEM_LATENCY,1)+1 (memory).
- Requests:
  - New requests are ignored while busy_o=1.
  - A request held by the previous owner loses to any other requester; it wins only if it is alone.
  - Simultaneous requests resolve by round-robin only; no starvation.
  - Back-to-back transactions have exactly one IDLE cycle between DONE and the next GRANT.

Optional Feature:
- Macro: SNOOP_BUS_STATS_EN.
- When defined:
  - Adds outputs txn_count_o[15:0] and flush_count_o[15:0].
  - txn_count_o increments on every BCAST cycle.
  - flush_count_o increments on every BCAST cycle with a non-owner flush, excluding Upgr.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: the ports exist and are tied to 0; no counter logic.

Test Plan:
- Reset, then bus_req_i=2'b01 with cpu_msg slice0=1 (Rd), addr=2'b10, no flush, MEM_LATENCY=4 -> gnt[0] at cycle 1; bus_msg_o=1 and bus_addr_o=2 at cycle 2; data_valid_o=2'b01 at cycle 7.
- CPU1 RdX addr 1 with flush_i[0]=1 during BCAST -> data_valid_o=2'b10 at cycle 3; flush_i[1] high at the same time is ignored.
- bus_req_i=2'b11 held continuously, both Rd -> grants alternate CPU0, CPU1, CPU0, CPU1; each GRANT is preceded by exactly one IDLE cycle.
- CPU0 Upgr addr 3 with flush_i[1]=1 -> DONE at cycle 3, no MEM_WAIT.
- Granted CPU0 drives msg 0 (and separately msg 6) -> no BCAST and no data_valid; busy_o falls the next cycle; the next grant goes to CPU1 if it is requesting.
- rst_i asserted during MEM_WAIT -> all outputs 0 immediately; no data_valid after release; with SNOOP_BUS_STATS_EN, counters read 0.

Source files
------------

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snooping-bus arbiter: grant, one-cycle broadcast, flush or memory fill, data-valid.
// Optional statistics counters are enabled by defining SNOOP_BUS_STATS_EN.
module snoop_bus_arbiter #(
  parameter int unsigned NUM_CPUS    = 2,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_CPUS-1:0]            bus_req_i,
  output logic [NUM_CPUS-1:0]            bus_gnt_o,
  input  logic [3*NUM_CPUS-1:0]          cpu_msg_i,
  input  logic [ADDR_WIDTH*NUM_CPUS-1:0] cpu_addr_i,
  input  logic [NUM_CPUS-1:0]            flush_i,
  output logic [2:0]                     bus_msg_o,
  output logic [ADDR_WIDTH-1:0]          bus_addr_o,
  output logic [NUM_CPUS-1:0]            bus_owner_o,
  output logic [NUM_CPUS-1:0]            data_valid_o,
  output logic                           busy_o,
  output logic [15:0]                    txn_count_o,
  output logic [15:0]                    flush_count_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CPUS);
  localparam int unsigned LAT   = (MEM_LATENCY == 0) ? 1 : MEM_LATENCY;
  localparam int unsigned CNT_W = $clog2(LAT + 1);
  localparam logic [2:0]  MSG_UPGR = 3'd3;

  typedef enum logic [2:0] {IDLE, GRANT, BCAST, MEM_WAIT, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d, last_q, last_d;
  logic [IDX_W-1:0]       cand, win;
  logic                   req_found;
  logic [2:0]             msg_q, msg_d, sel_msg;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, sel_addr;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CPUS-1:0]    owner_oh, peer_flush;

  // Round-robin search starting one past the previous owner, wrapping around.
  always_comb begin
    cand      = last_q;
    win       = last_q;
    req_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CPUS; k++) begin
      cand = (cand == IDX_W'(NUM_CPUS - 1)) ? '0 : cand + IDX_W'(1);
      if (!req_found && bus_req_i[cand]) begin
        req_found = 1'b1;
        win       = cand;
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    sel_msg  = '0;
    sel_addr = '0;
    for (int unsigned i = 0; i < NUM_CPUS; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_oh[i] = 1'b1;
        sel_msg     = cpu_msg_i[3*i +: 3];
        sel_addr    = cpu_addr_i[ADDR_WIDTH*i +: ADDR_WIDTH];
      end
    end
    peer_flush = flush_i & ~owner_oh;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_CPUS - 1);
      msg_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      msg_q   <= msg_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    msg_d   = msg_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_found) begin
          owner_d = win;
          state_d = GRANT;
        end
      end
      GRANT: begin
        msg_d  = sel_msg;
        addr_d = sel_addr;
        // Idle or undefined messages end the tenure without a broadcast.
        if (sel_msg == 3'd0 || sel_msg > MSG_UPGR) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          state_d = BCAST;
        end
      end
      BCAST: begin
        if (msg_q == MSG_UPGR || |peer_flush) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(LAT);
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_gnt_o    = '0;
    bus_owner_o  = '0;
    data_valid_o = '0;
    bus_msg_o    = '0;
    bus_addr_o   = '0;
    busy_o       = (state_q != IDLE);
    unique case (state_q)
      GRANT: begin
        bus_gnt_o   = owner_oh;
        bus_owner_o = owner_oh;
      end
      BCAST: begin
        bus_owner_o = owner_oh;
        bus_msg_o   = msg_q;
        bus_addr_o  = addr_q;
      end
      MEM_WAIT: bus_owner_o = owner_oh;
      DONE: begin
        bus_owner_o  = owner_oh;
        data_valid_o = owner_oh;
      end
      default: ;
    endcase
  end

`ifdef SNOOP_BUS_STATS_EN
  logic [15:0] txn_q, txn_d, flc_q, flc_d;

  always_comb begin
    txn_d = txn_q;
    flc_d = flc_q;
    if (state_q == BCAST) begin
      if (txn_q != '1) txn_d = txn_q + 16'd1;
      if (msg_q != MSG_UPGR && |peer_flush && flc_q != '1) flc_d = flc_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      txn_q <= '0;
      flc_q <= '0;
    end else begin
      txn_q <= txn_d;
      flc_q <= flc_d;
    end
  end

  assign txn_count_o   = txn_q;
  assign flush_count_o = flc_q;
`else
  assign txn_count_o   = '0;
  assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: directed scenarios plus randomized transactions.
module tb_snoop_bus_arbiter;

  localparam int N    = 2;
  localparam int AW   = 2;
  localparam int LAT  = 4;
  localparam int LEFF = (LAT == 0) ? 1 : LAT;
  localparam int MW   = 3 * N;
  localparam int AVW  = AW * N;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   bus_req_i = '0;
  logic [MW-1:0]  cpu_msg_i = '0;
  logic [AVW-1:0] cpu_addr_i = '0;
  logic [N-1:0]   flush_i = '0;
  logic [N-1:0]   bus_gnt_o, bus_owner_o, data_valid_o;
  logic [2:0]     bus_msg_o;
  logic [AW-1:0]  bus_addr_o;
  logic           busy_o;
  logic [15:0]    txn_count_o, flush_count_o;

  snoop_bus_arbiter #(
    .NUM_CPUS   (N),
    .ADDR_WIDTH (AW),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus_req_i    (bus_req_i),
    .bus_gnt_o    (bus_gnt_o),
    .cpu_msg_i    (cpu_msg_i),
    .cpu_addr_i   (cpu_addr_i),
    .flush_i      (flush_i),
    .bus_msg_o    (bus_msg_o),
    .bus_addr_o   (bus_addr_o),
    .bus_owner_o  (bus_owner_o),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .txn_count_o  (txn_count_o),
    .flush_count_o(flush_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          w;
    int          t_gnt;
    int          t_end;
    bit          abort;
    logic [2:0]  msg;
    logic [AW-1:0] addr;
  } rec_t;

  rec_t q[$];
  bit   mon_en = 1'b0;

  // Reference model state: previous owner and statistics.
  int last_own = N - 1;
  int exp_txn  = 0;
  int exp_fl   = 0;

  function automatic logic [N-1:0] oh(input int w);
    return N'(1) << w;
  endfunction

  function automatic int rr(input int last, input logic [N-1:0] r);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: expected outputs each cycle follow from the active scoreboard record.
  always @(negedge clk) begin : mon
    rec_t         cur;
    bit           cur_v;
    logic [N-1:0] e_gnt, e_own, e_dv;
    logic [2:0]   e_msg;
    logic [AW-1:0] e_addr;
    logic         e_busy;
    if (!mon_en) begin
      cur_v = 1'b0;
    end else begin
      if (q.size() > 0 && q[0].t_gnt == cyc) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
      end
      e_gnt = '0; e_own = '0; e_dv = '0; e_msg = '0; e_addr = '0; e_busy = 1'b0;
      if (cur_v && cyc >= cur.t_gnt && cyc <= cur.t_end) begin
        e_own  = oh(cur.w);
        e_busy = 1'b1;
        if (cyc == cur.t_gnt) e_gnt = oh(cur.w);
        if (!cur.abort && cyc == cur.t_gnt + 1) begin
          e_msg  = cur.msg;
          e_addr = cur.addr;
        end
        if (!cur.abort && cyc == cur.t_end) e_dv = oh(cur.w);
      end
      chk("gnt",   32'(bus_gnt_o),    32'(e_gnt));
      chk("owner", 32'(bus_owner_o),  32'(e_own));
      chk("busy",  32'(busy_o),       32'(e_busy));
      chk("msg",   32'(bus_msg_o),    32'(e_msg));
      chk("addr",  32'(bus_addr_o),   32'(e_addr));
      chk("dv",    32'(data_valid_o), 32'(e_dv));
    end
  end

  task automatic do_txn(input logic [N-1:0] r, input logic [MW-1:0] mv,
                        input logic [AVW-1:0] av, input logic [N-1:0] fv);
    rec_t       rec;
    int         t0, w;
    logic [2:0] m;
    bit         peer, fast;
    t0         = cyc;
    bus_req_i  = r;
    cpu_msg_i  = mv;
    cpu_addr_i = av;
    flush_i    = N'($urandom);
    if (r == '0) begin
      @(negedge clk);
      return;
    end
    w         = rr(last_own, r);
    m         = mv[3*w +: 3];
    peer      = ((fv & ~oh(w)) != '0);
    fast      = (m == 3'd3) || peer;
    rec.w     = w;
    rec.t_gnt = t0 + 1;
    rec.msg   = m;
    rec.addr  = av[AW*w +: AW];
    rec.abort = (m == 3'd0) || (m > 3'd3);
    rec.t_end = rec.abort ? t0 + 1 : (fast ? t0 + 3 : t0 + 3 + LEFF);
    if (!rec.abort) begin
      exp_txn++;
      if (m != 3'd3 && peer) exp_fl++;
    end
    last_own = w;
    q.push_back(rec);
    @(negedge clk);
    bus_req_i = N'($urandom);
    flush_i   = N'($urandom);
    @(negedge clk);
    while (cyc <= rec.t_end) begin
      bus_req_i  = N'($urandom);
      cpu_msg_i  = MW'($urandom);
      cpu_addr_i = AVW'($urandom);
      flush_i    = (cyc == t0 + 2) ? fv : N'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"},   32'(bus_gnt_o),     0);
    chk({nm, "_owner"}, 32'(bus_owner_o),   0);
    chk({nm, "_dv"},    32'(data_valid_o),  0);
    chk({nm, "_msg"},   32'(bus_msg_o),     0);
    chk({nm, "_addr"},  32'(bus_addr_o),    0);
    chk({nm, "_busy"},  32'(busy_o),        0);
    chk({nm, "_txn"},   32'(txn_count_o),   0);
    chk({nm, "_flc"},   32'(flush_count_o), 0);
  endtask

  task automatic chk_counters(input string nm);
`ifdef SNOOP_BUS_STATS_EN
    chk({nm, "_txn"}, 32'(txn_count_o),   32'(exp_txn));
    chk({nm, "_flc"}, 32'(flush_count_o), 32'(exp_fl));
`else
    chk({nm, "_txn"}, 32'(txn_count_o),   0);
    chk({nm, "_flc"}, 32'(flush_count_o), 0);
`endif
  endtask

  function automatic logic [2:0] rand_msg();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 3'(1 + (r % 3));
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin : stim
    logic [MW-1:0] mv;
    int t0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Memory fill, flush from peer, round-robin alternation, upgrade, aborts.
    do_txn(2'b01, {3'd2, 3'd1}, {2'd0, 2'd2}, 2'b00);
    do_txn(2'b10, {3'd2, 3'd0}, {2'd1, 2'd0}, 2'b11);
    repeat (4) do_txn(2'b11, {3'd1, 3'd1}, AVW'($urandom), 2'b00);
    do_txn(2'b01, {3'd0, 3'd3}, {2'd0, 2'd3}, 2'b10);
    do_txn(2'b01, {3'd1, 3'd0}, {2'd1, 2'd1}, 2'b00);
    do_txn(2'b11, {3'd1, 3'd1}, {2'd2, 2'd1}, 2'b00);
    do_txn(2'b01, {3'd1, 3'd6}, {2'd1, 2'd1}, 2'b00);
    do_txn(2'b11, {3'd2, 3'd2}, {2'd3, 2'd0}, 2'b01);

    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < N; c++) mv[3*c +: 3] = rand_msg();
      do_txn(($urandom_range(0, 9) == 0) ? '0 : N'($urandom), mv,
             AVW'($urandom), N'($urandom));
    end
    bus_req_i = '0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 0);
    chk_counters("stats");

    // Reset during MEM_WAIT abandons the transaction.
    mon_en = 1'b0;
    @(negedge clk);
    t0         = cyc;
    bus_req_i  = 2'b01;
    cpu_msg_i  = {3'd1, 3'd1};
    cpu_addr_i = {2'd1, 2'd1};
    flush_i    = '0;
    @(negedge clk);
    bus_req_i = '0;
    while (cyc < t0 + 4) @(negedge clk);
    chk("busy_before_rst", 32'(busy_o), 1);
    chk("owner_before_rst", 32'(bus_owner_o), 32'(oh(0)));
    #2 rst = 1'b1;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b0;
    last_own = N - 1;
    exp_txn  = 0;
    exp_fl   = 0;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_dv",   32'(data_valid_o), 0);
      chk("post_rst_busy", 32'(busy_o),       0);
    end
    chk_counters("post_rst");

    mon_en = 1'b1;
    do_txn(2'b11, {3'd1, 3'd2}, {2'd2, 2'd1}, 2'b10);
    bus_req_i = '0;
    repeat (3) @(negedge clk);
    chk("sb_empty_end", 32'(q.size()), 0);
    chk_counters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
